// File: rtl/reg_bank_ctrl_pkg.sv
// Shared types for the register-bank controller: command opcodes and FSM states.
package reg_bank_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_SUB   = 2'd1,
        OP_AND   = 2'd2,
        OP_LOADI = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/reg_bank_ctrl_if.sv
// Command and bank-port bundle between a requester/bank (master) and the controller (slave).
interface reg_bank_ctrl_if #(
    parameter int W = 7,
    parameter int N = 2
);
    import reg_bank_ctrl_pkg::*;

    localparam int AW = 2**N;

    logic          cmd_valid;
    logic          cmd_ready;
    op_e           cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs1;
    logic [AW-1:0] cmd_rs2;
    logic [W-1:0]  cmd_imm;

    logic          bank_we;
    logic [AW-1:0] bank_addr_rd;
    logic [AW-1:0] bank_addr_rs1;
    logic [AW-1:0] bank_addr_rs2;
    logic [W-1:0]  bank_data_in;
    logic [W-1:0]  bank_rs1;
    logic [W-1:0]  bank_rs2;

    logic          done;
    logic          err;
    logic [W-1:0]  result;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  bank_rs1, bank_rs2,
        output cmd_ready, bank_we, bank_addr_rd, bank_addr_rs1, bank_addr_rs2,
        output bank_data_in, done, err, result
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output bank_rs1, bank_rs2,
        input  cmd_ready, bank_we, bank_addr_rd, bank_addr_rs1, bank_addr_rs2,
        input  bank_data_in, done, err, result
    );

endinterface

// File: rtl/reg_bank_ctrl_alu.sv
// Combinational ALU for reg_bank_ctrl. Define REG_BANK_CTRL_SAT_EN to make
// ADD clamp at all-ones and SUB clamp at zero instead of wrapping.
module reg_alu
    import reg_bank_ctrl_pkg::*;
#(
    parameter int W = 7
) (
    input  op_e          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] imm,
    output logic [W-1:0] y
);

    logic [W:0] sum;
    logic [W:0] diff;

    // The extra top bit is the carry for ADD and the borrow for SUB.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y = '0;
        case (op)
`ifdef REG_BANK_CTRL_SAT_EN
            OP_ADD:   y = sum[W]  ? '1 : sum[W-1:0];
            OP_SUB:   y = diff[W] ? '0 : diff[W-1:0];
`else
            OP_ADD:   y = sum[W-1:0];
            OP_SUB:   y = diff[W-1:0];
`endif
            OP_AND:   y = a & b;
            OP_LOADI: y = imm;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/reg_bank_ctrl.sv
// Four-state controller: accept a command, read two bank registers, compute,
// then write the result back. One command per four cycles.
module reg_bank_ctrl
    import reg_bank_ctrl_pkg::*;
#(
    parameter int W = 7,
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           reset,
    reg_bank_ctrl_if.slave bus
);

    localparam int            AW   = 2**N;
    localparam logic [AW-1:0] NREG = AW'(2**N);

    state_e        state_q, state_d;
    logic          ready_q, ready_d;
    logic          we_q, we_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    op_e           op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [W-1:0]  imm_q, imm_d;
    logic          inv_q, inv_d;
    logic [W-1:0]  opa_q, opa_d;
    logic [W-1:0]  opb_q, opb_d;
    logic [W-1:0]  result_q, result_d;
    logic [AW-1:0] addr_rd_q, addr_rd_d;
    logic [AW-1:0] addr_rs1_q, addr_rs1_d;
    logic [AW-1:0] addr_rs2_q, addr_rs2_d;
    logic [W-1:0]  data_q, data_d;

    logic [W-1:0]  alu_y;
    logic          cmd_inv;

    // LOADI has no sources, so only its destination is range-checked.
    assign cmd_inv = (bus.cmd_rd >= NREG) ||
                     ((bus.cmd_op != OP_LOADI) &&
                      ((bus.cmd_rs1 >= NREG) || (bus.cmd_rs2 >= NREG)));

    reg_alu #(.W(W)) u_alu (
        .op  (op_q),
        .a   (opa_q),
        .b   (opb_q),
        .imm (imm_q),
        .y   (alu_y)
    );

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        op_d       = op_q;
        rd_d       = rd_q;
        imm_d      = imm_q;
        inv_d      = inv_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        result_d   = result_q;
        addr_rd_d  = addr_rd_q;
        addr_rs1_d = addr_rs1_q;
        addr_rs2_d = addr_rs2_q;
        data_d     = data_q;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (ready_q && bus.cmd_valid) begin
                    state_d    = ST_READ;
                    ready_d    = 1'b0;
                    op_d       = bus.cmd_op;
                    rd_d       = bus.cmd_rd;
                    imm_d      = bus.cmd_imm;
                    inv_d      = cmd_inv;
                    addr_rs1_d = bus.cmd_rs1;
                    addr_rs2_d = bus.cmd_rs2;
                end
            end
            ST_READ: begin
                opa_d   = bus.bank_rs1;
                opb_d   = bus.bank_rs2;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                result_d  = inv_q ? '0 : alu_y;
                data_d    = inv_q ? '0 : alu_y;
                addr_rd_d = rd_q;
                we_d      = ~inv_q;
                done_d    = 1'b1;
                err_d     = inv_q;
                state_d   = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            op_q       <= OP_ADD;
            rd_q       <= '0;
            imm_q      <= '0;
            inv_q      <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            result_q   <= '0;
            addr_rd_q  <= '0;
            addr_rs1_q <= '0;
            addr_rs2_q <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            done_q     <= done_d;
            err_q      <= err_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            imm_q      <= imm_d;
            inv_q      <= inv_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            result_q   <= result_d;
            addr_rd_q  <= addr_rd_d;
            addr_rs1_q <= addr_rs1_d;
            addr_rs2_q <= addr_rs2_d;
            data_q     <= data_d;
        end
    end

    assign bus.cmd_ready     = ready_q;
    assign bus.bank_we       = we_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
    assign bus.result        = result_q;
    assign bus.bank_addr_rd  = addr_rd_q;
    assign bus.bank_addr_rs1 = addr_rs1_q;
    assign bus.bank_addr_rs2 = addr_rs2_q;
    assign bus.bank_data_in  = data_q;

endmodule
